sync_filter_bus: RTL
====================

SYNC_FILTER_BUS -- requirements
Module: sync_filter_bus

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter STAGES, default 2, giving the synchroniser flop depth per channel (2..4).
REQ-003 The block SHALL have parameter FILTER_CNT, default 4, giving the consecutive synchronised cycles required before an output changes (0 = filter bypassed, max 255).
REQ-004 The block SHALL have parameter RESET_VAL, default all-zeros, WIDTH bits, giving the reset value of every chain flop and of result.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port datain, input, WIDTH bits: asynchronous channel inputs.
REQ-008 The block SHALL have port result, output, WIDTH bits: synchronised, filtered channel values, registered.
REQ-009 The block SHALL have port changed, output, 1 bit: one-cycle pulse when any result bit changes.
REQ-010 The block SHALL have ports rise and fall, output, WIDTH bits each, only when SYNC_EDGE_DETECT_EN is defined: per-channel one-cycle edge pulses.

Function
REQ-011 Each channel SHALL pass datain[i] through a STAGES-deep flop chain; the last flop is the synchronised value s[i], and no logic sits between chain flops.
REQ-012 With FILTER_CNT = 0, result[i] SHALL equal s[i] delayed one clock, so datain-to-result latency is STAGES+1 cycles.
REQ-013 With FILTER_CNT > 0, each channel SHALL hold a counter of width clog2(FILTER_CNT+1); in any cycle where s[i] equals result[i], the counter clears to 0.
REQ-014 In any cycle where s[i] differs from result[i], the counter SHALL increment; when the counter already equals FILTER_CNT-1, result[i] takes s[i] on that edge and the counter clears.
REQ-015 A stable datain step SHALL therefore reach result after exactly STAGES+FILTER_CNT cycles; a pulse shorter than FILTER_CNT synchronised cycles SHALL never reach result.
REQ-016 A single opposite-value cycle during counting SHALL restart the count from 0; the counter never exceeds FILTER_CNT-1 and never wraps.
REQ-017 changed SHALL be registered and asserted in exactly the cycle in which result first shows a new value, for one cycle; simultaneous changes on several channels give one pulse.
REQ-018 Channels SHALL be fully independent: no counter or result bit depends on another channel.

Reset
REQ-019 While resetn is low, all chain flops and result SHALL equal RESET_VAL, and all counters, changed, rise and fall SHALL equal 0, asynchronously.
REQ-020 Reset asserted mid-count SHALL discard the count; after release, filtering restarts from RESET_VAL with counters at 0.
REQ-021 The first edge after resetn deasserts SHALL produce no changed, rise or fall pulse unless a real result change occurs.

Configuration
REQ-022 With macro SYNC_EDGE_DETECT_EN defined, rise[i] (result 0->1) and fall[i] (result 1->0) SHALL be registered one-cycle pulses aligned with changed.
REQ-023 Without SYNC_EDGE_DETECT_EN, the rise and fall ports and their flops SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Package sync_pkg SHALL hold the parameter bounds (STAGES_MIN=2, STAGES_MAX=4, FILTER_CNT_MAX=255) and a counter-width function; the top SHALL check the bounds at elaboration.
REQ-025 One sub-module, sync_filter_bit, SHALL implement a single channel (chain, counter, result bit), and the top SHALL instantiate it WIDTH times and OR-reduce the changes into changed.

Verification (WIDTH=8, STAGES=2, FILTER_CNT=4, RESET_VAL=0, macro defined unless stated)
REQ-026 Reset: hold resetn=0 with datain=8'hFF -> result=8'h00, changed=0, rise=fall=8'h00 throughout.
REQ-027 Step: datain[0] 0->1 at cycle 0, held -> result[0]=1 first at cycle 6; changed=1 and rise=8'h01 at cycle 6 only.
REQ-028 Glitch/restart: datain[3] high 3 cycles, low 1, then high -> no change from the first pulse; result[3]=1 six cycles after the final rise.
REQ-029 Multi-channel: datain 8'h00->8'hA5 in one cycle -> result=8'hA5 at cycle 6, a single changed pulse, rise=8'hA5; then ->8'h00 gives fall=8'hA5.
REQ-030 Reset mid-count: resetn low at cycle 4 of a bit-1 step -> result[1] stays 0, and after release the step needs a full 6 cycles.
REQ-031 Bypass: FILTER_CNT=0, STAGES=3, macro undefined -> each datain step reaches result after 4 cycles; a 1-cycle pulse passes through.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared parameter bounds and the helper that sizes the per-channel
// debounce counter for sync_filter_bus.
package sync_pkg;

   localparam int WIDTH_MIN      = 1;
   localparam int WIDTH_MAX      = 32;
   localparam int STAGES_MIN     = 2;
   localparam int STAGES_MAX     = 4;
   localparam int FILTER_CNT_MAX = 255;

   // Width needed to count 0..filter_cnt; never narrower than one bit.
   function automatic int cnt_width(input int filter_cnt);
      int w;
      w = $clog2(filter_cnt + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: STAGES-deep synchroniser chain, optional consecutive-cycle
// filter counter and the registered result bit.
module sync_filter_bit
   import sync_pkg::*;
#(
   parameter int   STAGES     = 2,
   parameter int   FILTER_CNT = 4,
   parameter logic RESET_BIT  = 1'b0
) (
   input  logic clock,
   input  logic resetn,
   input  logic din,
   output logic result,
   output logic update
);

   logic [STAGES-1:0] chain_q;
   logic              sync_s;
   logic              result_q;
   logic              result_d;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         chain_q <= {STAGES{RESET_BIT}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], din};
      end
   end

   assign sync_s = chain_q[STAGES-1];

   generate
      if (FILTER_CNT == 0) begin : g_bypass
         assign result_d = sync_s;
      end else begin : g_filter
         localparam int            CW       = cnt_width(FILTER_CNT);
         localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // Any agreeing sample restarts the count; result moves only after
         // FILTER_CNT disagreeing samples in a row.
         always_comb begin
            cnt_d    = cnt_q;
            result_d = result_q;
            if (sync_s == result_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               result_d = sync_s;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         result_q <= RESET_BIT;
      end else begin
         result_q <= result_d;
      end
   end

   assign update = (result_d != result_q);
   assign result = result_q;

endmodule

// File: rtl/sync_filter_bus.sv
// Bus of independent synchronise-and-filter channels with a shared change pulse.
// Define SYNC_EDGE_DETECT_EN to add the per-channel rise/fall pulse outputs.
module sync_filter_bus
   import sync_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               STAGES     = 2,
   parameter int               FILTER_CNT = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] result,
   output logic             changed
`ifdef SYNC_EDGE_DETECT_EN
   ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`endif
);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
         $error("sync_filter_bus: WIDTH %0d out of range", WIDTH);
      end
      if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
         $error("sync_filter_bus: STAGES %0d out of range", STAGES);
      end
      if (FILTER_CNT < 0 || FILTER_CNT > FILTER_CNT_MAX) begin : g_bad_filter
         $error("sync_filter_bus: FILTER_CNT %0d out of range", FILTER_CNT);
      end
   endgenerate

   logic [WIDTH-1:0] update_s;
   logic             changed_q;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         sync_filter_bit #(
            .STAGES     (STAGES),
            .FILTER_CNT (FILTER_CNT),
            .RESET_BIT  (RESET_VAL[gi])
         ) u_bit (
            .clock  (clock),
            .resetn (resetn),
            .din    (datain[gi]),
            .result (result[gi]),
            .update (update_s[gi])
         );
      end
   endgenerate

   // Registered so the pulse lands in the same cycle result shows the new value.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= |update_s;
      end
   end

   assign changed = changed_q;

`ifdef SYNC_EDGE_DETECT_EN
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= update_s & ~result;
         fall_q <= update_s & result;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`endif

endmodule
